// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-decode stage: opcode values, the
// immediate format code and the XLEN-independent part of the stage payload.
package imm_pkg;

    // Major opcodes (instr[6:0]) recognised by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    // Immediate format code as seen on out_fmt
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    // Fixed-width part of a stage entry; the XLEN-wide fields (pc, imm,
    // target) live beside it in the stage because a package struct cannot
    // follow the XLEN parameter.
    typedef struct packed {
        logic [31:0] instr;
        fmt_e        fmt;
        logic        illegal;
    } payload_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Purely combinational immediate decoder. Classifies the opcode into a
// format, flags unsupported encodings, builds the XLEN-wide immediate and
// says whether the control-flow target is pc-relative.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o,
    output logic            pc_rel_o
);

    logic is_rv64;

    assign is_rv64 = (XLEN == 64);

    // Opcode classification: format, legality and pc-relative target select
    always_comb begin
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        pc_rel_o  = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (instr_i[6:0])
                OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: begin
                    fmt_o = FMT_I;
                end
                OP_IMM32: begin
                    if (is_rv64) begin
                        fmt_o = FMT_I;
                    end else begin
                        illegal_o = 1'b1;
                    end
                end
                OP_STORE: begin
                    fmt_o = FMT_S;
                end
                OP_BRANCH: begin
                    fmt_o    = FMT_B;
                    pc_rel_o = 1'b1;
                end
                OP_LUI: begin
                    fmt_o = FMT_U;
                end
                OP_AUIPC: begin
                    fmt_o    = FMT_U;
                    pc_rel_o = 1'b1;
                end
                OP_JAL: begin
                    fmt_o    = FMT_J;
                    pc_rel_o = 1'b1;
                end
                OP_SYSTEM: begin
                    fmt_o = instr_i[14] ? FMT_Z : FMT_I;
                end
                OP_REG: begin
                    fmt_o = FMT_NONE;
                end
                OP_REG32: begin
                    if (!is_rv64) begin
                        illegal_o = 1'b1;
                    end
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

    // Immediate assembly; signed casts sign-extend each field to XLEN,
    // the CSR immediate is the only zero-extended one
    always_comb begin
        imm_o = '0;
        case (fmt_o)
            FMT_I: imm_o = XLEN'($signed(instr_i[31:20]));
            FMT_S: imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            FMT_B: imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                          instr_i[11:8], 1'b0}));
            FMT_U: imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
            FMT_J: imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                          instr_i[30:21], 1'b0}));
            FMT_Z: imm_o = XLEN'(instr_i[19:15]);
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode pipeline stage. Instructions are decoded on
// the input side, so the output register and the optional skid entry both
// hold fully decoded payloads. With SKID_EN the upstream ready is taken
// from a register; without it the stage is a single register whose ready
// looks through to out_ready.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_target,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Decoded view of the incoming instruction
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    logic            dec_pc_rel;
    payload_t        dec_pl;

    // Output register
    logic            out_valid_q, out_valid_d;
    payload_t        out_pl_q;
    logic [XLEN-1:0] out_pc_q;
    logic [XLEN-1:0] out_imm_q;
    logic [XLEN-1:0] out_tgt_q;

    // Skid entry, always younger than the output register entry
    logic            skid_valid_q, skid_valid_d;
    payload_t        skid_pl_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [XLEN-1:0] skid_imm_q;
    logic [XLEN-1:0] skid_tgt_q;

    // Illegal-instruction counter
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Handshake and load controls
    logic accept;
    logic xfer;
    logic load_out_new;
    logic load_out_skid;
    logic load_skid;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal),
        .pc_rel_o  (dec_pc_rel)
    );

    assign dec_target     = in_pc + (dec_pc_rel ? dec_imm : XLEN'(4));
    assign dec_pl.instr   = in_instr;
    assign dec_pl.fmt     = dec_fmt;
    assign dec_pl.illegal = dec_illegal;

    // Ready is held low while reset is applied so nothing is taken in
    // before the stage is out of reset
    assign in_ready = !rst && (SKID_EN ? !skid_valid_q : (!out_valid_q || out_ready));
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    // Occupancy control: decide what each register loads this cycle
    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (xfer) begin
                load_out_skid = 1'b1;
                skid_valid_d  = accept;
                load_skid     = accept;
            end
        end else if (out_valid_q && !xfer) begin
            if (accept && SKID_EN) begin
                skid_valid_d = 1'b1;
                load_skid    = 1'b1;
            end
        end else begin
            out_valid_d  = accept;
            load_out_new = accept;
        end
    end

    // Counter next state: count delivered illegal entries, stick at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (xfer && out_pl_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Valid flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Output payload; only changes on a load so data holds during a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pl_q  <= '0;
            out_pc_q  <= '0;
            out_imm_q <= '0;
            out_tgt_q <= '0;
        end else if (load_out_skid) begin
            out_pl_q  <= skid_pl_q;
            out_pc_q  <= skid_pc_q;
            out_imm_q <= skid_imm_q;
            out_tgt_q <= skid_tgt_q;
        end else if (load_out_new) begin
            out_pl_q  <= dec_pl;
            out_pc_q  <= in_pc;
            out_imm_q <= dec_imm;
            out_tgt_q <= dec_target;
        end
    end

    // Skid payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_pl_q  <= '0;
            skid_pc_q  <= '0;
            skid_imm_q <= '0;
            skid_tgt_q <= '0;
        end else if (load_skid) begin
            skid_pl_q  <= dec_pl;
            skid_pc_q  <= in_pc;
            skid_imm_q <= dec_imm;
            skid_tgt_q <= dec_target;
        end
    end

    // Illegal counter register; flush deliberately leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_pl_q.instr;
    assign out_pc      = out_pc_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_pl_q.fmt;
    assign out_illegal = out_pl_q.illegal;
    assign out_target  = out_tgt_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
Registered, XLEN-parametrised immediate-decode pipeline stage between fetch and register-read. Per accepted instruction it emits:
- the sign/zero-extended immediate;
- a format code;
- an illegal flag;
- a precomputed control-flow target (pc+imm or pc+4).
Valid/ready handshakes on both sides, optional 2-entry skid buffer, synchronous flush, and a saturating illegal-instruction counter.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates sign-extended to XLEN.
SKID_EN, 1, 1 = registered in_ready with 2-entry skid; 0 = single register, combinational in_ready.
CNT_W, 16, width of illegal_cnt.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  instruction valid.
in_ready  out  1  stage can accept.
in_instr  in  32  instruction word.
in_pc  in  XLEN  instruction address.
out_valid  out  1  output valid.
out_ready  in  1  downstream accepts.
out_instr  out  32  registered instruction.
out_pc  out  XLEN  registered pc.
out_imm  out  XLEN  decoded immediate.
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
out_illegal  out  1  unsupported encoding.
out_target  out  XLEN  branch/jump/auipc target.
illegal_cnt  out  CNT_W  saturating count of illegal instructions delivered.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, skid empty, illegal_cnt=0.
  - out_imm, out_pc, out_target and out_instr = 0; out_fmt=0; out_illegal=0.
  - in_ready=0 while rst is high; in_ready=1 the first cycle after release.
- Accept when in_valid&&in_ready; transfer out when out_valid&&out_ready. Latency: accepted instruction appears on out_* next cycle (empty stage).
- Decode on opcode instr[6:0]; s = instr[31] extended to XLEN:
  - 0000011, 0010011, 0011011, 1100111, 0001111 -> I: {s, instr[31:20]}.
  - 0100011 -> S: {s, instr[31:25], instr[11:7]}.
  - 1100011 -> B: {s, instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 0110111, 0010111 -> U: {s above bit 31, instr[31:12], 12'b0}. Sign-extended above bit 31 when XLEN=64.
  - 1101111 -> J: {s, instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 1110011: instr[14]=1 -> Z, zero-extended instr[19:15]; otherwise I.
  - 0110011, 0111011 -> NONE, imm=0, legal.
- Illegal encodings: any other opcode, or instr[1:0]!=2'b11, gives fmt=NONE, imm=0, illegal=1.
  - 0011011 and 0111011 are illegal when XLEN=32.
- Target: pc+imm for B, J and opcode 0010111; pc+4 otherwise. Addition modulo 2^XLEN; wrap is not flagged.
- SKID_EN=1:
  - in_ready = !skid_valid (registered).
  - Accept while out_valid&&!out_ready -> entry stored in skid.
  - When out transfers and skid_valid -> skid moves to out, and a simultaneous new accept refills skid. Program order is preserved.
  - Accept while out empty, or out transferring with skid empty -> entry goes directly to out.
- SKID_EN=0: in_ready = !out_valid || out_ready; no skid.
- Flush:
  - out_valid=0 and skid cleared next edge.
  - in_valid in the flush cycle is discarded.
  - An out transfer in the flush cycle still counts as delivered.
  - in_ready follows normal rules during flush.
- illegal_cnt:
  - +1 on each out transfer with out_illegal=1.
  - Holds at 2^CNT_W-1.
  - Not cleared by flush.
- Output data holds stable while out_valid&&!out_ready.
- Reset asserted mid-transfer: all state cleared immediately; no partial transfer.

Decomposition:
- Shared package imm_pkg:
  - opcode constants (OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_FENCE, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM, OP_REG, OP_REG32);
  - format enum fmt_e (FMT_NONE..FMT_Z);
  - packed struct for the stage payload.
- Sub-module imm_decode_comb: combinational decode producing imm/fmt/illegal, parametrised by XLEN. Instantiated once on the input side, so out and skid both store decoded payloads.

Test Plan:
- XLEN=32: in_instr=0xFFF00093 (addi x1,x0,-1), pc=0x100 -> next cycle out_imm=0xFFFFFFFF, fmt=1, target=0x104.
- XLEN=64: in_instr=0xFE000EE3 (beq, imm -4), pc=0x1000 -> imm=0xFFFFFFFFFFFFFFFC, fmt=3, target=0xFFC. Also lui 0x80000037 -> imm=0xFFFFFFFF80000000.
- csrrwi 0x3002D073 -> fmt=6, imm=5. in_instr=0x00000000 -> illegal=1, fmt=0, illegal_cnt increments on transfer.
- SKID_EN=1: out_ready=0, push 3 instrs -> 2 accepted, in_ready=0. Release out_ready -> outputs in order A, B, and C is accepted once the skid empties.
- flush with out and skid full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing delivered.
- CNT_W=2: deliver 5 illegal instrs -> illegal_cnt=3. Assert rst asynchronously mid-stream -> out_valid=0, illegal_cnt=0 without clock.
